// File: rtl/atmega_pcint.sv
// Pin-change input stage: sync, glitch filter and AVR PCINT flag.
// Ports: clk/rst, I/O bus (addr_dat, wr/rd, data), io_in pads, pin_filt, int_req/ack.
module atmega_pcint #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int PORT_WIDTH        = 8,
  parameter int PCMSK_ADDR        = 'h6B,
  parameter int PCIFR_ADDR        = 'h3B,
  parameter int PCICR_ADDR        = 'h68,
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [PORT_WIDTH-1:0]        bus_dat_in,
  output logic [PORT_WIDTH-1:0]        bus_dat_out,
  input  logic [PORT_WIDTH-1:0]        io_in,
  output logic [PORT_WIDTH-1:0]        pin_filt,
  output logic                         int_req,
  input  logic                         int_ack
);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_MSK =
    BUS_ADDR_DATA_LEN'(PCMSK_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_IFR =
    BUS_ADDR_DATA_LEN'(PCIFR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_ICR =
    BUS_ADDR_DATA_LEN'(PCICR_ADDR);
  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [8:0] PRIME_LAST =
    9'(SYNC_STAGES + FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] sync_q;
  logic [PORT_WIDTH-1:0]                  sync;
  logic [PORT_WIDTH-1:0]                  filt;
  logic [PORT_WIDTH-1:0]                  filt_nxt;
  logic [PORT_WIDTH-1:0][7:0]             cnt;
  logic [PORT_WIDTH-1:0][7:0]             cnt_nxt;
  logic [PORT_WIDTH-1:0]                  pcmsk;
  logic                                   pcif;
  logic                                   pcie;
  logic                                   primed;
  logic [8:0]                             prime_cnt;
  logic                                   chg;
  logic                                   chg_q;
  logic                                   sel_msk;
  logic                                   sel_ifr;
  logic                                   sel_icr;
  logic                                   ifr_clr;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign pin_filt = filt;
  assign int_req  = pcif & pcie;

  assign sel_msk = (addr_dat == A_MSK);
  assign sel_ifr = (addr_dat == A_IFR);
  assign sel_icr = (addr_dat == A_ICR);
  assign ifr_clr = wr_dat & sel_ifr & bus_dat_in[0];

  // Until primed, filt tracks sync so idle-high pins do not
  // look like a change when the chain fills after reset.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = cnt;
    for (int i = 0; i < PORT_WIDTH; i++) begin
      if (!primed) begin
        filt_nxt[i] = sync[i];
        cnt_nxt[i]  = '0;
      end else if (sync[i] == filt[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        filt_nxt[i] = sync[i];
        cnt_nxt[i]  = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + 8'd1;
      end
    end
  end

  // Mask is sampled on the toggle edge; flag lands one edge later.
  assign chg = primed & (|((filt_nxt ^ filt) & pcmsk));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      filt   <= '0;
      cnt    <= '0;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
      filt   <= filt_nxt;
      cnt    <= cnt_nxt;
      chg_q  <= chg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      if (prime_cnt == PRIME_LAST) primed <= 1'b1;
      else prime_cnt <= prime_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcmsk <= '0;
      pcie  <= 1'b0;
    end else if (wr_dat) begin
      if (sel_msk) pcmsk <= bus_dat_in;
      if (sel_icr) pcie  <= bus_dat_in[0];
    end
  end

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcif <= 1'b0;
    else if (chg_q) pcif <= 1'b1;
    else if (int_ack | ifr_clr) pcif <= 1'b0;
  end

  always_comb begin
    bus_dat_out = '0;
    if (rst && rd_dat) begin
      unique case (1'b1)
        sel_msk: bus_dat_out = pcmsk;
        sel_ifr: bus_dat_out = PORT_WIDTH'(pcif);
        sel_icr: bus_dat_out = PORT_WIDTH'(pcie);
        default: bus_dat_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_pcint.sv
// Bench for atmega_pcint: vector table plus corner-case sequences.
// Expected values queue on stimulus and are popped at sample time.
module tb_atmega_pcint;

  localparam logic [7:0] A_MSK = 8'h6B;
  localparam logic [7:0] A_IFR = 8'h3B;
  localparam logic [7:0] A_ICR = 8'h68;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr_dat;
  logic       wr_dat;
  logic       rd_dat;
  logic [7:0] bus_dat_in;
  logic [7:0] bus_dat_out;
  logic [7:0] io_in;
  logic [7:0] pin_filt;
  logic       int_req;
  logic       int_ack;

  atmega_pcint dut (
    .clk         (clk),
    .rst         (rst),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_dat_out),
    .io_in       (io_in),
    .pin_filt    (pin_filt),
    .int_req     (int_req),
    .int_ack     (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    logic [7:0] io;
    logic [7:0] msk;
    logic       pcie;
    logic [7:0] filt;
    logic       pcif;
    logic       req;
  } vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [7:0] act);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%h", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s got=%h want=%h", e.name, act, e.val);
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr_dat   = a;
    bus_dat_in = d;
    wr_dat     = 1'b1;
    tick();
    wr_dat     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr_dat = a;
    rd_dat   = 1'b1;
    #1;
    d        = bus_dat_out;
    rd_dat   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    logic       seen;

    vt[0] = '{8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1};
    vt[1] = '{8'h21, 8'h01, 1'b1, 8'h21, 1'b0, 1'b0};
    vt[2] = '{8'h01, 8'h20, 1'b0, 8'h01, 1'b1, 1'b0};
    vt[3] = '{8'h81, 8'h7F, 1'b1, 8'h81, 1'b0, 1'b0};
    vt[4] = '{8'h7E, 8'h80, 1'b1, 8'h7E, 1'b1, 1'b1};
    vt[5] = '{8'h7E, 8'hFF, 1'b1, 8'h7E, 1'b0, 1'b0};

    rst        = 1'b0;
    addr_dat   = '0;
    wr_dat     = 1'b0;
    rd_dat     = 1'b0;
    bus_dat_in = '0;
    io_in      = 8'hFF;
    int_ack    = 1'b0;

    // reset state with pads idling high
    repeat (3) tick();
    push("rst_filt", 8'h00);
    pop(pin_filt);
    push("rst_req", 8'h00);
    pop({7'b0, int_req});
    push("rst_rd", 8'h00);
    rd(A_MSK, v);
    pop(v);

    // release, mask everything at once, no spurious flag
    rst = 1'b1;
    wr(A_MSK, 8'hFF);
    repeat (5) tick();
    push("prime_filt", 8'hFF);
    pop(pin_filt);
    repeat (4) tick();
    push("prime_ifr", 8'h00);
    rd(A_IFR, v);
    pop(v);
    push("prime_msk", 8'hFF);
    rd(A_MSK, v);
    pop(v);

    io_in = 8'h00;
    repeat (8) tick();

    for (int i = 0; i < 6; i++) begin
      wr(A_MSK, vt[i].msk);
      wr(A_ICR, {7'b0, vt[i].pcie});
      wr(A_IFR, 8'h01);
      io_in = vt[i].io;
      push($sformatf("vec%0d_filt", i), vt[i].filt);
      push($sformatf("vec%0d_ifr", i), {7'b0, vt[i].pcif});
      push($sformatf("vec%0d_req", i), {7'b0, vt[i].req});
      repeat (8) tick();
      pop(pin_filt);
      rd(A_IFR, v);
      pop(v);
      pop({7'b0, int_req});
    end

    // step latency and ack
    wr(A_MSK, 8'h01);
    wr(A_ICR, 8'h01);
    wr(A_IFR, 8'h01);
    io_in = 8'h7F;
    repeat (5) tick();
    push("lat_filt5", 8'h00);
    pop({7'b0, pin_filt[0]});
    tick();
    push("lat_filt6", 8'h01);
    pop({7'b0, pin_filt[0]});
    push("lat_req6", 8'h00);
    pop({7'b0, int_req});
    tick();
    push("lat_req7", 8'h01);
    pop({7'b0, int_req});
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    push("ack_req", 8'h00);
    pop({7'b0, int_req});

    // glitch filter on pin 3
    io_in = 8'h00;
    repeat (8) tick();
    wr(A_MSK, 8'h08);
    wr(A_IFR, 8'h01);
    seen = 1'b0;
    io_in[3] = 1'b1;
    repeat (3) begin
      tick();
      seen |= pin_filt[3];
    end
    io_in[3] = 1'b0;
    repeat (12) begin
      tick();
      seen |= pin_filt[3];
    end
    push("glitch3_seen", 8'h00);
    pop({7'b0, seen});
    push("glitch3_ifr", 8'h00);
    rd(A_IFR, v);
    pop(v);
    seen = 1'b0;
    io_in[3] = 1'b1;
    repeat (4) begin
      tick();
      seen |= pin_filt[3];
    end
    io_in[3] = 1'b0;
    repeat (12) begin
      tick();
      seen |= pin_filt[3];
    end
    push("pulse4_seen", 8'h01);
    pop({7'b0, seen});
    push("pulse4_ifr", 8'h01);
    rd(A_IFR, v);
    pop(v);

    // ack on the set edge: set wins
    wr(A_MSK, 8'h01);
    wr(A_ICR, 8'h01);
    wr(A_IFR, 8'h01);
    io_in[0] = 1'b1;
    repeat (6) tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    push("setwin_req", 8'h01);
    pop({7'b0, int_req});
    wr(A_IFR, 8'h00);
    push("wr0_keep", 8'h01);
    pop({7'b0, int_req});
    wr(A_IFR, 8'h01);
    push("wr1_clr", 8'h00);
    pop({7'b0, int_req});

    // reset mid-count with flag pending
    io_in[0] = 1'b0;
    repeat (8) tick();
    push("pre_rst_req", 8'h01);
    pop({7'b0, int_req});
    io_in[0] = 1'b1;
    repeat (4) tick();
    #1 rst = 1'b0;
    #1;
    push("arst_req", 8'h00);
    pop({7'b0, int_req});
    push("arst_filt", 8'h00);
    pop(pin_filt);
    push("arst_msk", 8'h00);
    rd(A_MSK, v);
    pop(v);
    push("arst_ifr", 8'h00);
    rd(A_IFR, v);
    pop(v);
    push("arst_icr", 8'h00);
    rd(A_ICR, v);
    pop(v);
    repeat (2) tick();
    rst = 1'b1;
    wr(A_MSK, 8'h01);
    wr(A_ICR, 8'h01);
    repeat (10) tick();
    push("post_rst_req", 8'h00);
    pop({7'b0, int_req});
    push("post_rst_filt", 8'h01);
    pop(pin_filt);
    io_in[0] = 1'b0;
    repeat (8) tick();
    push("post_rst_chg", 8'h01);
    pop({7'b0, int_req});

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atmega_pcint.md
Name: atmega_pcint

Overview:
- Pin-change input stage placed directly upstream of the ATmega PIO block.
- Synchronises and glitch-filters raw pad inputs, then drives the cleaned levels on pin_filt to the PIO io_in.
- Detects level changes on masked pins and raises an AVR-style pin-change interrupt flag, with a request/acknowledge handshake to the interrupt controller.
- Registers (PCMSK, PCIFR, PCICR) sit on the same 8-bit I/O data bus as the PIO.

Parameters:
- BUS_ADDR_DATA_LEN, 8, width of addr_dat.
- PORT_WIDTH, 8, number of pins; 1..8.
- PCMSK_ADDR, 'h6B, address of the per-pin change-mask register.
- PCIFR_ADDR, 'h3B, address of the flag register; bit0 = PCIF.
- PCICR_ADDR, 'h68, address of the control register; bit0 = PCIE.
- SYNC_STAGES, 2, synchroniser depth; legal 2..4.
- FILTER_CYCLES, 4, consecutive stable cycles required before pin_filt follows; legal 1..255.

Ports:
- clk, in, 1, system clock; all state on rising edge.
- rst, in, 1, reset. Asynchronous, active-low: 0 = reset.
- addr_dat, in, BUS_ADDR_DATA_LEN, register address.
- wr_dat, in, 1, write strobe; single cycle.
- rd_dat, in, 1, read strobe.
- bus_dat_in, in, PORT_WIDTH, write data.
- bus_dat_out, out, PORT_WIDTH, read data; combinational.
- io_in, in, PORT_WIDTH, raw asynchronous pad inputs.
- pin_filt, out, PORT_WIDTH, synchronised and filtered levels; feeds PIO io_in.
- int_req, out, 1, interrupt request = PCIF & PCIE.
- int_ack, in, 1, one-cycle acknowledge from the interrupt controller; clears PCIF.

Behaviour:
- Reset (rst=0, asynchronous): sync chain, pin_filt, filter counters, PCMSK, PCIF, PCIE and primed all go to 0. int_req=0. bus_dat_out=0 while rst=0.
- Sync: per pin, an SYNC_STAGES flop chain produces sync[i].
- Filter, per pin, with an 8-bit counter cnt[i]:
  - sync==filt: cnt <= 0.
  - sync!=filt and cnt==FILTER_CYCLES-1: filt <= sync, cnt <= 0.
  - sync!=filt otherwise: cnt <= cnt+1.
  - A pulse shorter than FILTER_CYCLES cycles is never propagated.
- Latency: a clean io_in step reaches pin_filt after SYNC_STAGES+FILTER_CYCLES rising edges.
- Priming:
  - primed is set SYNC_STAGES+FILTER_CYCLES cycles after reset release.
  - While primed=0, filt <= sync directly and no flags are set. This prevents a spurious edge when pins idle high.
- Change detect: on the edge where filt[i] toggles with PCMSK[i]=1 and primed=1, PCIF is set on the following edge.
  - io_in step to int_req latency is SYNC_STAGES+FILTER_CYCLES+1 cycles when PCIE=1.
  - Both rising and falling transitions count.
  - PCMSK is sampled at the toggle cycle; a later mask change does not retro-set the flag.
- PCIF clear sources: int_ack=1; or a write to PCIFR with bus_dat_in[0]=1. Writing 0 has no effect.
- Simultaneous set and clear in one cycle: set wins, PCIF stays 1.
- PCIE = PCICR bit0 and only gates int_req. PCIF still sets while PCIE=0, and int_req rises immediately when PCIE is later set.
- Writes: PCMSK <= bus_dat_in; PCICR bit0 <= bus_dat_in[0]. Other bits are ignored.
- Reads (rd_dat=1): PCMSK returns mask; PCIFR returns {0…,PCIF}; PCICR returns {0…,PCIE}. Any other address or rd_dat=0 returns 0.
- Reset asserted mid-filter or with PCIF pending clears everything immediately. Priming restarts after release.

Test Plan:
- Reset release with io_in=8'hFF, PCMSK written 8'hFF at once → pin_filt=8'hFF after 6 cycles; PCIF stays 0; reading PCIFR returns 8'h00.
- Primed, PCMSK=8'h01, PCIE=1, io_in[0] 0→1 step → pin_filt[0]=1 at edge 6; int_req=1 at edge 7. int_ack pulse → int_req=0 next cycle.
- io_in[3] glitch high for 3 cycles (FILTER_CYCLES=4), PCMSK=8'h08 → pin_filt[3] stays 0; PCIF stays 0. A 4-cycle pulse → pin_filt[3] toggles and PCIF=1.
- Change on pin 5 with PCMSK=8'h01 → pin_filt[5] follows, PCIF=0. Same change with PCMSK=8'h20 and PCIE=0 → PCIF=1, int_req=0; then write PCICR=8'h01 → int_req=1 next cycle.
- int_ack in the same cycle as a new masked toggle → PCIF remains 1. Write PCIFR=8'h01 → PCIF=0; write PCIFR=8'h00 while set → PCIF remains 1.
- Assert rst=0 mid-count and with PCIF=1 → int_req drops asynchronously; all reads return 0; after release, no flag is raised until a genuine post-prime change.
